// File: rtl/fifo_word_packer.sv
// Packs PACK_RATIO show-ahead FIFO entries into one wide word on a valid/ready port.
// Partial words leave on flush or after TIMEOUT idle cycles.

module fifo_word_packer_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int CW         = 3,
  parameter int IDX        = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pop,
  input  logic                  clr,
  input  logic [CW-1:0]         cnt,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  en,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] acc;

  always_ff @(posedge clk) begin
    if (rst || clr)                     acc <= '0;
    else if (pop && cnt == CW'(IDX))    acc <= din;
  end

  // Lanes at or above the fill level never leak stale bytes
  assign en = (cnt > CW'(IDX));
  assign q  = en ? acc : '0;
endmodule

module fifo_word_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_rd_data,
  output logic                             fifo_rd_en,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
  output logic [PACK_RATIO-1:0]            out_keep
);
  localparam int CW = $clog2(PACK_RATIO + 1);
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [CW-1:0] cnt;
  logic          flush_pending;
  logic [IW-1:0] idle;
  logic [1:0]    state;
  logic          pop, launch, slot_free, timed_out;

  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] lane_q;
  logic [PACK_RATIO-1:0]                 lane_en;

  always_comb begin
    state = ST_FILL;
    if (cnt == '0)                    state = ST_EMPTY;
    else if (cnt == CW'(PACK_RATIO))  state = ST_FULL;
  end

  assign timed_out  = (TIMEOUT > 0) && (idle == IW'(TIMEOUT));
  assign slot_free  = !out_valid || out_ready;
  assign launch     = slot_free && ((state == ST_FULL) ||
                      ((state != ST_EMPTY) && (flush_pending || flush || timed_out)));
  assign fifo_rd_en = !rst && !fifo_empty && (state != ST_FULL) && !launch;
  assign pop        = fifo_rd_en && !fifo_empty;

  genvar i;
  generate
    for (i = 0; i < PACK_RATIO; i++) begin : g_lane
      fifo_word_packer_lane #(
        .DATA_WIDTH(DATA_WIDTH), .CW(CW), .IDX(i)
      ) u_lane (
        .clk (clk),
        .rst (rst),
        .pop (pop),
        .clr (launch),
        .cnt (cnt),
        .din (fifo_rd_data),
        .en  (lane_en[i]),
        .q   (lane_q[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      flush_pending <= 1'b0;
      idle          <= '0;
    end else if (launch) begin
      cnt           <= '0;
      flush_pending <= 1'b0;
      idle          <= '0;
    end else begin
      if (pop) cnt <= cnt + CW'(1);
      if (flush && state != ST_EMPTY) flush_pending <= 1'b1;
      if (pop)
        idle <= '0;
      else if (TIMEOUT > 0 && state != ST_EMPTY && !timed_out)
        idle <= idle + IW'(1);
    end
  end

  // A launch may replace an accepted word in the same edge, keeping valid high
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
    end else if (launch) begin
      out_valid <= 1'b1;
      out_data  <= lane_q;
      out_keep  <= lane_en;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
